// File: rtl/chnl_tx_arb.sv
// rtl/chnl_tx_arb.sv - burst-granular round-robin arbiter sharing one chnl_tx stream
// A win costs one idle bubble; the holder then owns the stream until BURST beats, i_last or timeout.
module chnl_tx_arb #(
  parameter int N        = 4,
  parameter int TX_WIDTH = 32,
  parameter int BURST    = 8,
  parameter int TIMEOUT  = 64,
  parameter int SW       = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N-1:0]          i_val,
  output logic [N-1:0]          i_rdy,
  input  logic [N-1:0]          i_last,
  input  logic [N*TX_WIDTH-1:0] i_data,
  output logic                  o_val,
  input  logic                  o_rdy,
  output logic [TX_WIDTH-1:0]   o_data,
  output logic [SW-1:0]         o_src,
  output logic                  o_busy,
  output logic                  o_abort
);
  localparam int BCW = $clog2(BURST) + 1;
  localparam int ICW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [BCW-1:0] BEAT_LAST = BCW'(BURST - 1);
  localparam logic [ICW-1:0] IDLE_MAX  = ICW'(TIMEOUT);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] src_q, src_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic [BCW-1:0] beat_q, beat_d;
  logic [ICW-1:0] idle_q, idle_d;

  logic                win_found;
  logic [SW-1:0]       win_idx;
  logic [SW-1:0]       cand;
  logic                g_val;
  logic                g_last;
  logic [TX_WIDTH-1:0] g_data;
  logic                timeout_hit;

  assign g_val       = i_val[src_q];
  assign g_last      = i_last[src_q];
  assign g_data      = i_data[int'(src_q) * TX_WIDTH +: TX_WIDTH];
  assign timeout_hit = (TIMEOUT != 0) && (idle_q == IDLE_MAX);
  assign o_src       = src_q;

  // Search starts just after the last winner, so a releasing source ranks last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= N; i++) begin
      cand = SW'((int'(ptr_q) + i) % N);
      if (!win_found && i_val[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    ptr_d   = ptr_q;
    beat_d  = beat_q;
    idle_d  = idle_q;
    i_rdy   = '0;
    o_val   = 1'b0;
    o_data  = '0;
    o_busy  = 1'b0;
    o_abort = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          src_d   = win_idx;
          ptr_d   = win_idx;
          beat_d  = '0;
          idle_d  = '0;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if (timeout_hit) begin
          // Forced release: the stream stays closed this cycle.
          o_abort = 1'b1;
          state_d = S_IDLE;
        end else begin
          o_busy       = 1'b1;
          o_val        = g_val;
          o_data       = g_data;
          i_rdy[src_q] = o_rdy;
          if (g_val && o_rdy) begin
            beat_d = beat_q + 1'b1;
            idle_d = '0;
            if ((beat_q == BEAT_LAST) || g_last) begin
              state_d = S_IDLE;
            end
          end else if (!g_val && (TIMEOUT != 0) && (idle_q != IDLE_MAX)) begin
            idle_d = idle_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      ptr_q   <= SW'(N - 1);
      beat_q  <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      ptr_q   <= ptr_d;
      beat_q  <= beat_d;
      idle_q  <= idle_d;
    end
  end

endmodule

// File: tb/tb_chnl_tx_arb.sv
// tb/tb_chnl_tx_arb.sv - randomized and directed checks of chnl_tx_arb against a cycle reference model
module tb_chnl_tx_arb;
  localparam int N       = 4;
  localparam int W       = 32;
  localparam int BURST   = 8;
  localparam int TIMEOUT = 4;
  localparam int SW      = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   i_val, i_rdy, i_last;
  logic [N*W-1:0] i_data;
  logic           o_val, o_rdy, o_busy, o_abort;
  logic [W-1:0]   o_data;
  logic [SW-1:0]  o_src;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  chnl_tx_arb #(.N(N), .TX_WIDTH(W), .BURST(BURST), .TIMEOUT(TIMEOUT), .SW(SW)) dut (
    .clk(clk), .rst_n(rst_n), .i_val(i_val), .i_rdy(i_rdy), .i_last(i_last),
    .i_data(i_data), .o_val(o_val), .o_rdy(o_rdy), .o_data(o_data), .o_src(o_src),
    .o_busy(o_busy), .o_abort(o_abort)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: holder=-1 means nobody owns the stream.
  int holder, taken, quiet, last_win, m_src, beat_src;
  int aborts, beats;
  int grant_src[$];
  // Stimulus bookkeeping
  int mode;
  int budget[N];
  int sent[N];

  task automatic model_reset();
    holder = -1; taken = 0; quiet = 0; last_win = N - 1; m_src = 0; beat_src = -1;
    aborts = 0; beats = 0; grant_src.delete();
    for (int k = 0; k < N; k++) begin budget[k] = 0; sent[k] = 0; end
  endtask

  task automatic model_cycle();
    logic [N-1:0] e_rdy;
    logic         e_val, e_busy, e_abort;
    logic [W-1:0] e_data;
    int           h;
    e_rdy = '0; e_val = 0; e_busy = 0; e_abort = 0; e_data = '0;
    beat_src = -1;
    h = holder;
    check_eq("o_src", o_src, m_src);
    if (h < 0) begin
      for (int s = 1; s <= N; s++) begin
        int k;
        k = (last_win + s) % N;
        if (holder < 0 && i_val[k]) begin
          holder = k; last_win = k; m_src = k; taken = 0; quiet = 0;
          grant_src.push_back(k);
        end
      end
    end else if (quiet >= TIMEOUT) begin
      e_abort = 1; holder = -1; aborts++;
    end else begin
      e_busy = 1; e_val = i_val[h]; e_data = i_data[h*W +: W]; e_rdy[h] = o_rdy;
      if (i_val[h] && o_rdy) begin
        beat_src = h; beats++; taken++; quiet = 0; sent[h]++;
        if (budget[h] > 0) budget[h]--;
        if (taken == BURST || i_last[h]) holder = -1;
      end else if (!i_val[h]) begin
        quiet++;
      end
    end
    check_eq("o_val", o_val, e_val);
    check_eq("i_rdy", i_rdy, e_rdy);
    check_eq("o_busy", o_busy, e_busy);
    check_eq("o_abort", o_abort, e_abort);
    if (e_val) check_eq("o_data", o_data, e_data);
  endtask

  task automatic drive_next();
    for (int k = 0; k < N; k++) begin
      logic nv, nl;
      if (!(i_val[k] && beat_src != k)) begin
        nv = 0; nl = 0;
        case (mode)
          1, 6:    nv = (budget[k] > 0) || (mode == 6 && k == 3);
          2, 5:    nv = 1;
          3: begin nv = (k == 1 || k == 2); nl = (k == 1 && sent[1] == 2); end
          4: begin nv = ($urandom_range(0, 9) < 5); nl = ($urandom_range(0, 5) == 0); end
          default: nv = 0;
        endcase
        i_val[k]        = nv;
        i_last[k]       = nl;
        i_data[k*W +: W] = $urandom;
      end
    end
    case (mode)
      4:       o_rdy = ($urandom_range(0, 9) < 7);
      5:       o_rdy = ~o_rdy;
      default: o_rdy = 1'b1;
    endcase
  endtask

  task automatic run(input int cycles);
    repeat (cycles) begin
      @(negedge clk);
      model_cycle();
      @(posedge clk);
      #1;
      drive_next();
    end
  endtask

  task automatic start_phase(input int m);
    rst_n = 0; i_val = '0; i_last = '0; i_data = '0; o_rdy = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst_n = 1;
    mode = m;
    if (m == 1) budget[2] = 20;
    if (m == 6) budget[0] = 2;
    drive_next();
  endtask

  initial begin
    mode = 0;
    model_reset();
    rst_n = 0; o_rdy = 1; i_val = '1; i_last = '0; i_data = '1;
    #13;
    check_eq("rst_o_val", o_val, 0);
    check_eq("rst_i_rdy", i_rdy, 0);
    check_eq("rst_o_busy", o_busy, 0);
    check_eq("rst_o_abort", o_abort, 0);
    check_eq("rst_o_src", o_src, 0);

    // Single requester: 8 + 8 + 4 beats, last grant closed by timeout.
    start_phase(1);
    run(40);
    check_eq("single_beats", beats, 20);
    check_eq("single_aborts", aborts, 1);
    check_eq("single_grants", grant_src.size(), 3);
    foreach (grant_src[i]) check_eq("single_src", grant_src[i], 2);

    // All continuously valid: four 9-cycle grants in order 0..3.
    start_phase(2);
    run(36);
    check_eq("rr_beats", beats, 32);
    check_eq("rr_grants", grant_src.size(), 4);
    for (int i = 0; i < 4 && i < grant_src.size(); i++) check_eq("rr_order", grant_src[i], i);

    // i_last on requester 1's third beat hands over to 2.
    start_phase(3);
    run(8);
    check_eq("last_grants", grant_src.size(), 2);
    if (grant_src.size() >= 2) begin
      check_eq("last_first", grant_src[0], 1);
      check_eq("last_next", grant_src[1], 2);
    end
    check_eq("last_beats_r1", sent[1], 3);

    // Backpressure toggling on every cycle.
    start_phase(5);
    run(40);
    check_eq("bp_aborts", aborts, 0);

    // Timeout with requester 3 waiting.
    start_phase(6);
    run(10);
    check_eq("to_aborts", aborts, 1);
    check_eq("to_grants", grant_src.size(), 2);
    if (grant_src.size() >= 2) begin
      check_eq("to_first", grant_src[0], 0);
      check_eq("to_next", grant_src[1], 3);
    end

    // Long random run.
    start_phase(4);
    run(3000);

    // Async reset while beat 5 of the first grant is in flight.
    start_phase(2);
    run(5);
    check_eq("ar_busy_pre", o_busy, 1);
    #2;
    rst_n = 0;
    #1;
    check_eq("ar_o_val", o_val, 0);
    check_eq("ar_i_rdy", i_rdy, 0);
    check_eq("ar_o_busy", o_busy, 0);
    start_phase(2);
    run(12);
    check_eq("ar_restart", grant_src.size() > 0 ? grant_src[0] : -1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
